// File: rtl/pkt_pkg.sv
// Shared definitions for the stream packer: control word layout and packer state.
package pkt_pkg;

  localparam int CTRL_WIDTH      = 32;
  localparam int CTL_FIELD_W     = 8;
  localparam int SRC_PORT_LSB    = 24;
  localparam int DST_PORT_LSB    = 16;
  localparam int PCIE_PORT_LSB   = 8;
  localparam int NEXT_OUTPUT_LSB = 0;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } state_t;

endpackage

// File: rtl/stream_packer_if.sv
// Beat-in / word-out bundle of the stream packer; master drives beats, slave is the packer.
interface stream_packer_if
  import pkt_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = pkt_pkg::CTRL_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH / IN_WIDTH + 1)
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [CTRL_WIDTH-1:0] cfg_ctl;
  logic                  out_wr;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctl;
  logic                  out_sop;
  logic                  out_eop;
  logic [CNT_W-1:0]      out_bytes;
  logic                  out_trunc;
  logic [31:0]           pkt_cnt;

  modport master (
    output in_data, in_valid, in_last, cfg_ctl, out_ready,
    input  in_ready, out_wr, out_data, out_ctl, out_sop, out_eop, out_bytes, out_trunc, pkt_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, cfg_ctl, out_ready,
    output in_ready, out_wr, out_data, out_ctl, out_sop, out_eop, out_bytes, out_trunc, pkt_cnt
  );
endinterface

// File: rtl/packer_out_reg.sv
// Output holding register: loads a finished word, holds it under backpressure, counts packets.
module packer_out_reg #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [CTRL_WIDTH-1:0] load_ctl,
  input  logic                  load_sop,
  input  logic                  load_eop,
  input  logic [CNT_W-1:0]      load_bytes,
  input  logic                  load_trunc,
  input  logic                  out_ready,
  output logic                  out_free,
  output logic                  out_wr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctl,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [CNT_W-1:0]      out_bytes,
  output logic                  out_trunc,
  output logic [31:0]           pkt_cnt
);
  logic handshake;

  assign handshake = out_wr && out_ready;
  assign out_free  = !out_wr || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctl   <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_bytes <= '0;
      out_trunc <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      // A reload in the handshake cycle keeps out_wr high, so words stream without bubbles.
      if (load) begin
        out_wr    <= 1'b1;
        out_data  <= load_data;
        out_ctl   <= load_ctl;
        out_sop   <= load_sop;
        out_eop   <= load_eop;
        out_bytes <= load_bytes;
        out_trunc <= load_trunc;
      end else if (handshake) begin
        out_wr <= 1'b0;
      end
      if (handshake && out_eop) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end
endmodule

// File: rtl/stream_packer.sv
// Narrow-to-wide packer: gathers IN_WIDTH beats into left-aligned DATA_WIDTH words per packet.
module stream_packer
  import pkt_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = pkt_pkg::CTRL_WIDTH,
  parameter int MAX_WORDS  = 32
) (
  input logic           clk,
  input logic           rst,
  stream_packer_if.slave bus
);
  localparam int BEATS = DATA_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int WC_W  = $clog2(MAX_WORDS + 1);
  localparam int ACC_W = DATA_WIDTH - IN_WIDTH;

  generate
    if ((DATA_WIDTH % IN_WIDTH) != 0 || BEATS < 2) begin : g_width_check
      $error("stream_packer: DATA_WIDTH must be a multiple (>=2) of IN_WIDTH");
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [ACC_W-1:0]      acc_reg;
  logic [CNT_W-1:0]      beat_cnt_reg;
  logic [WC_W-1:0]       word_cnt_reg;
  logic                  in_pkt_reg;
  logic [CTRL_WIDTH-1:0] ctl_reg;

  logic                  out_free;
  logic                  in_ready;
  logic                  completing;
  logic                  last_word;
  logic                  collect_beat;
  logic                  emit;
  logic [DATA_WIDTH-1:0] beat_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CTRL_WIDTH-1:0] load_ctl;
  logic                  load_eop;
  logic                  load_trunc;

  assign completing   = (beat_cnt_reg == CNT_W'(BEATS - 1)) || bus.in_last;
  assign last_word    = (word_cnt_reg == WC_W'(MAX_WORDS - 1));
  assign collect_beat = bus.in_valid && in_ready && (state_reg == COLLECT);
  assign emit         = collect_beat && completing;
  assign beat_word    = {acc_reg, bus.in_data};
  // Shift the partial word up so the packet's first beat always sits in the MSBs.
  assign load_data    = beat_word << (IN_WIDTH * (BEATS - 1 - int'(beat_cnt_reg)));
  assign load_ctl     = in_pkt_reg ? ctl_reg : bus.cfg_ctl;
  assign load_eop     = bus.in_last || last_word;
  assign load_trunc   = !bus.in_last && last_word;
  assign bus.in_ready = in_ready;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      COLLECT: begin
        // Only a word-completing beat needs room in the output register.
        in_ready = rst && (!completing || out_free);
        if (emit && load_trunc) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        in_ready = rst;
        if (bus.in_valid && in_ready && bus.in_last) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= COLLECT;
      acc_reg      <= '0;
      beat_cnt_reg <= '0;
      word_cnt_reg <= '0;
      in_pkt_reg   <= 1'b0;
      ctl_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (collect_beat) begin
        if (!in_pkt_reg) begin
          ctl_reg    <= bus.cfg_ctl;
          in_pkt_reg <= 1'b1;
        end
        if (completing) begin
          acc_reg      <= '0;
          beat_cnt_reg <= '0;
          if (load_eop) begin
            word_cnt_reg <= '0;
            in_pkt_reg   <= 1'b0;
          end else begin
            word_cnt_reg <= word_cnt_reg + WC_W'(1);
          end
        end else begin
          acc_reg      <= beat_word[ACC_W-1:0];
          beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  packer_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH),
    .CNT_W     (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (emit),
    .load_data (load_data),
    .load_ctl  (load_ctl),
    .load_sop  (word_cnt_reg == '0),
    .load_eop  (load_eop),
    .load_bytes(beat_cnt_reg + CNT_W'(1)),
    .load_trunc(load_trunc),
    .out_ready (bus.out_ready),
    .out_free  (out_free),
    .out_wr    (bus.out_wr),
    .out_data  (bus.out_data),
    .out_ctl   (bus.out_ctl),
    .out_sop   (bus.out_sop),
    .out_eop   (bus.out_eop),
    .out_bytes (bus.out_bytes),
    .out_trunc (bus.out_trunc),
    .pkt_cnt   (bus.pkt_cnt)
  );
endmodule

// File: tb/tb_stream_packer.sv
// Randomized bench for stream_packer: packet-level word model, scoreboard and backpressure.
module tb_stream_packer;
  import pkt_pkg::*;

  localparam int IW    = 8;
  localparam int DW    = 480;
  localparam int CW    = 32;
  localparam int MW    = 4;
  localparam int BEATS = DW / IW;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctl;
    logic          sop;
    logic          eop;
    logic          trunc;
    int            bytes;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stream_packer_if #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  stream_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MAX_WORDS(MW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  word_t      exp_q[$];
  int         hs_cycle[$];
  logic [7:0] beats[$];
  int         stall_at[$];
  int         cycle = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_pkts = 0;
  int         ready_mode = 1;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Output side: 0 = hold off, 1 = always ready, 2 = random ready.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: every handshaken word must match the next modelled word.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_wr && bus.out_ready) begin
        hs_cycle.push_back(cycle);
        if (exp_q.size() == 0) begin
          check_val("unexpected_word", DW'(exp_q.size()), DW'(1));
        end else begin
          e = exp_q.pop_front();
          $display("word @%0d: bytes=%0d sop=%0b eop=%0b trunc=%0b ctl=%08h",
                   cycle, bus.out_bytes, bus.out_sop, bus.out_eop, bus.out_trunc, bus.out_ctl);
          check_val("data", bus.out_data, e.data);
          check_val("ctl", DW'(bus.out_ctl), DW'(e.ctl));
          check_val("sop", DW'(bus.out_sop), DW'(e.sop));
          check_val("eop", DW'(bus.out_eop), DW'(e.eop));
          check_val("trunc", DW'(bus.out_trunc), DW'(e.trunc));
          check_val("bytes", DW'(bus.out_bytes), DW'(e.bytes));
          if (e.eop) exp_pkts++;
        end
      end
    end
  end

  // Packet model: beats split into BEATS-sized words, first beat in MSBs, capped at MW words.
  task automatic build_expected(input logic [CW-1:0] ctl);
    word_t e;
    int n, nw, cnt;
    bit cut;
    n   = beats.size();
    nw  = (n + BEATS - 1) / BEATS;
    cut = (nw > MW);
    if (cut) nw = MW;
    for (int w = 0; w < nw; w++) begin
      cnt = n - w * BEATS;
      if (cnt > BEATS) cnt = BEATS;
      e.data = '0;
      for (int i = 0; i < cnt; i++) e.data[DW-1-IW*i -: IW] = beats[w*BEATS+i];
      e.ctl   = ctl;
      e.sop   = (w == 0);
      e.eop   = (w == nw - 1);
      e.trunc = e.eop && cut;
      e.bytes = cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pkt(input logic [CW-1:0] ctl, input int gap_pct, input bit with_last);
    int  st;
    bit  rdy;
    if (with_last) build_expected(ctl);
    stall_at = {};
    for (int i = 0; i < beats.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      bus.in_last  = with_last && (i == beats.size() - 1);
      bus.cfg_ctl  = (i == 0) ? ctl : $urandom;
      st = 0;
      forever begin
        @(negedge clk);
        rdy = bus.in_ready;
        @(posedge clk);
        #1;
        if (rdy) break;
        st++;
        if (st > 3000) begin
          check_val("in_ready_timeout", DW'(st), DW'(0));
          finish_run();
        end
      end
      stall_at.push_back(st);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check_val("drain", DW'(exp_q.size()), DW'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int stall_sum(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += stall_at[i];
    return s;
  endfunction

  initial begin
    int k;
    logic [CW-1:0] c;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.cfg_ctl  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_wr", DW'(bus.out_wr), DW'(0));
    check_val("rst_out_data", bus.out_data, DW'(0));
    check_val("rst_pkt_cnt", DW'(bus.pkt_cnt), DW'(0));
    check_val("rst_in_ready", DW'(bus.in_ready), DW'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Three-beat packet.
    beats = '{8'hA1, 8'hB2, 8'hC3};
    c = $urandom;
    send_pkt(c, 0, 1);
    drain();
    check_val("pkt_cnt_first", DW'(bus.pkt_cnt), DW'(1));

    // 61 beats: one full word then a one-beat word.
    beats = {};
    for (int i = 0; i <= 8'h3C; i++) beats.push_back(8'(i));
    send_pkt($urandom, 0, 1);
    drain();

    // Output held off: word 1 must stay put while beats 61..119 are accepted.
    ready_mode = 0;
    beats = {};
    for (int i = 0; i < 120; i++) beats.push_back(8'($urandom));
    fork
      send_pkt($urandom, 0, 1);
      begin
        repeat (200) @(posedge clk);
        @(negedge clk);
        check_val("hold_in_ready", DW'(bus.in_ready), DW'(0));
        check_val("hold_out_wr", DW'(bus.out_wr), DW'(1));
        check_val("hold_data", bus.out_data, exp_q[0].data);
        ready_mode = 1;
      end
    join
    check_val("hold_beat120_stalled", DW'(stall_at[119] != 0), DW'(1));
    check_val("hold_no_early_stall", DW'(stall_sum(60, 118)), DW'(0));
    drain();

    // Truncation at MW words; the discarded tail must never stall.
    ready_mode = 2;
    k = int'(bus.pkt_cnt);
    beats = {};
    for (int i = 0; i < 300; i++) beats.push_back(8'($urandom));
    send_pkt($urandom, 0, 1);
    check_val("discard_no_stall", DW'(stall_sum(240, 299)), DW'(0));
    drain();
    check_val("trunc_pkt_cnt", DW'(bus.pkt_cnt - 32'(k)), DW'(1));

    // Exactly MW full words ending on in_last: normal eop, no truncation.
    beats = {};
    for (int i = 0; i < MW * BEATS; i++) beats.push_back(8'($urandom));
    send_pkt($urandom, 20, 1);
    drain();

    // Back-to-back 60-beat packets with continuous valid: one word every 60 cycles.
    ready_mode = 1;
    k = hs_cycle.size();
    beats = {};
    for (int i = 0; i < BEATS; i++) beats.push_back(8'($urandom));
    send_pkt(32'h01020304, 0, 1);
    beats = {};
    for (int i = 0; i < BEATS; i++) beats.push_back(8'($urandom));
    send_pkt(32'h05060708, 0, 1);
    drain();
    check_val("b2b_spacing", DW'(hs_cycle[k+1] - hs_cycle[k]), DW'(BEATS));

    // Random lengths, gaps and backpressure.
    ready_mode = 2;
    for (int p = 0; p < 8; p++) begin
      beats = {};
      k = $urandom_range(1, 260);
      for (int i = 0; i < k; i++) beats.push_back(8'($urandom));
      send_pkt($urandom, 30, 1);
    end
    drain();
    check_val("rand_pkt_cnt", DW'(bus.pkt_cnt), DW'(exp_pkts));

    // Reset in the middle of a packet.
    ready_mode = 1;
    beats = {};
    for (int i = 0; i < 30; i++) beats.push_back(8'($urandom));
    send_pkt($urandom, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_rst_out_wr", DW'(bus.out_wr), DW'(0));
    check_val("mid_rst_out_data", bus.out_data, DW'(0));
    check_val("mid_rst_out_bytes", DW'(bus.out_bytes), DW'(0));
    check_val("mid_rst_out_ctl", DW'(bus.out_ctl), DW'(0));
    check_val("mid_rst_pkt_cnt", DW'(bus.pkt_cnt), DW'(0));
    exp_pkts = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    beats = '{8'h5A, 8'hC7};
    send_pkt($urandom, 0, 1);
    drain();
    check_val("post_rst_pkt_cnt", DW'(bus.pkt_cnt), DW'(1));

    finish_run();
  end
endmodule
